// File: rtl/pipe_ctrl.sv
// Hold/bubble sequencer for the five-stage MyProc2 pipeline: load-use stalls,
// taken-branch redirects, multi-cycle multiply stalls and HALT drain.
module pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_wr_en,
  input  logic                  exe_is_load,
  input  logic                  exe_mul,
  input  logic                  exe_br_taken,
  input  logic                  exe_halt,
  output logic                  pc_en,
  output logic                  pc_sel_br,
  output logic                  if_id_en,
  output logic                  id_exe_en,
  output logic                  exe_mem_en,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  exe_mem_flush,
  output logic                  mul_done,
  output logic                  halted,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MUL   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Start cycle counts as the first of MUL_CYCLES; the final cycle is cnt==0.
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 2);

  state_t     state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic       load_use;

  assign dbg_state = state;

  always_comb begin
    load_use = exe_is_load & exe_wr_en & (exe_rd != '0) &
               ((id_use_rs1 & (id_rs1 == exe_rd)) |
                (id_use_rs2 & (id_rs2 == exe_rd)));
  end

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_br     = 1'b0;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mul_done      = 1'b0;
    halted        = 1'b0;
    nxt_state     = state;
    nxt_cnt       = cnt;

    case (state)
      S_RUN: begin
        if (exe_br_taken) begin
          pc_sel_br    = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (exe_halt) begin
          pc_en        = 1'b0;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          nxt_cnt      = 4'd1;
          nxt_state    = S_DRAIN;
        end else if (exe_mul) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_en     = 1'b0;
          exe_mem_flush = 1'b1;
          nxt_cnt       = MUL_INIT;
          nxt_state     = S_MUL;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_exe_flush = 1'b1;
        end
      end
      S_MUL: begin
        if (cnt != 4'd0) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_en     = 1'b0;
          exe_mem_flush = 1'b1;
          nxt_cnt       = cnt - 4'd1;
        end else begin
          mul_done  = 1'b1;
          nxt_state = S_RUN;
        end
      end
      S_DRAIN: begin
        pc_en        = 1'b0;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        if (cnt == 4'd0) nxt_state = S_HALT;
        else             nxt_cnt   = cnt - 4'd1;
      end
      S_HALT: begin
        pc_en         = 1'b0;
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        exe_mem_flush = 1'b1;
        halted        = 1'b1;
      end
      default: nxt_state = S_RUN;
    endcase

    // Reset forces every control low immediately, not at the next edge.
    if (rst) begin
      pc_en         = 1'b0;
      pc_sel_br     = 1'b0;
      if_id_en      = 1'b0;
      id_exe_en     = 1'b0;
      exe_mem_en    = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_flush = 1'b0;
      mul_done      = 1'b0;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for single-cycle RUN decisions,
// then hand-written multiply, HALT and async-reset sequences.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_use_rs1, id_use_rs2, exe_wr_en, exe_is_load;
  logic       exe_mul, exe_br_taken, exe_halt;
  logic       pc_en, pc_sel_br, if_id_en, id_exe_en, exe_mem_en;
  logic       if_id_flush, id_exe_flush, exe_mem_flush, mul_done, halted;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Output vector order: pc_en pc_sel_br if_id_en id_exe_en exe_mem_en
  //                      if_id_flush id_exe_flush exe_mem_flush mul_done halted
  localparam logic [9:0] O_ZERO  = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] O_DEF   = 10'b1_0_1_1_1_0_0_0_0_0;
  localparam logic [9:0] O_LU    = 10'b0_0_0_1_1_0_1_0_0_0;
  localparam logic [9:0] O_BR    = 10'b1_1_1_1_1_1_1_0_0_0;
  localparam logic [9:0] O_MUL   = 10'b0_0_0_0_1_0_0_1_0_0;
  localparam logic [9:0] O_DONE  = 10'b1_0_1_1_1_0_0_0_1_0;
  localparam logic [9:0] O_DRAIN = 10'b0_0_1_1_1_1_1_0_0_0;
  localparam logic [9:0] O_HALT  = 10'b0_0_1_1_1_1_1_1_0_1;

  pipe_ctrl #(.REG_ADDR_W(5), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_rd(exe_rd), .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load),
    .exe_mul(exe_mul), .exe_br_taken(exe_br_taken), .exe_halt(exe_halt),
    .pc_en(pc_en), .pc_sel_br(pc_sel_br),
    .if_id_en(if_id_en), .id_exe_en(id_exe_en), .exe_mem_en(exe_mem_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush),
    .mul_done(mul_done), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, wr, load, br;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] outs();
    return {pc_en, pc_sel_br, if_id_en, id_exe_en, exe_mem_en,
            if_id_flush, id_exe_flush, exe_mem_flush, mul_done, halted};
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; exe_wr_en = 0; exe_is_load = 0;
    exe_mul = 0; exe_br_taken = 0; exe_halt = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_tests++;
    if (dbg_state !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] rs1, rs2, rd,
                         input logic use1, use2, wr, load, br,
                         input logic [9:0] exp);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.use1 = use1; v.use2 = use2; v.wr = wr; v.load = load; v.br = br;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //       name             rs1 rs2 rd  u1 u2 wr ld br  expected
    add_vec("idle",           0,  0,  0,  0, 0, 0, 0, 0,  O_DEF);
    add_vec("lu_rs2_r3",      1,  3,  3,  0, 1, 1, 1, 0,  O_LU);
    add_vec("after_lu",       0,  0,  0,  0, 0, 0, 0, 0,  O_DEF);
    add_vec("lu_rd0",         0,  0,  0,  1, 1, 1, 1, 0,  O_DEF);
    add_vec("lu_rs1_r7",      7,  2,  7,  1, 0, 1, 1, 0,  O_LU);
    add_vec("rs1_not_used",   7,  2,  7,  0, 0, 1, 1, 0,  O_DEF);
    add_vec("no_wr_en",       7,  7,  7,  1, 1, 0, 1, 0,  O_DEF);
    add_vec("not_load",       7,  7,  7,  1, 1, 1, 0, 0,  O_DEF);
    add_vec("lu_rs2_r31",     4, 31, 31,  1, 1, 1, 1, 0,  O_LU);
    add_vec("br_over_lu",     1,  3,  3,  0, 1, 1, 1, 1,  O_BR);
    add_vec("br_alone",       0,  0,  0,  0, 0, 0, 0, 1,  O_BR);
    add_vec("rs_mismatch",    5,  6,  9,  1, 1, 1, 1, 0,  O_DEF);

    // Reset: controls stay low even with an event pending
    clear_inputs();
    rst = 1;
    exe_br_taken = 1;
    #2;
    check("reset_outs", O_ZERO);
    check_state("reset_state", 2'd0);
    next_cycle();
    check("reset_held", O_ZERO);
    rst = 0;
    exe_br_taken = 0;
    #1;
    check("post_reset_def", O_DEF);

    foreach (vecs[i]) begin
      next_cycle();
      clear_inputs();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; exe_rd = vecs[i].rd;
      id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
      exe_wr_en = vecs[i].wr; exe_is_load = vecs[i].load;
      exe_br_taken = vecs[i].br;
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // Multiply with MUL_CYCLES=4: 3 stall cycles, then mul_done
    next_cycle();
    clear_inputs();
    exe_mul = 1;
    #1; check("mul_start", O_MUL);
    next_cycle();
    exe_br_taken = 1; exe_halt = 1;
    id_use_rs1 = 1; id_rs1 = 2; exe_rd = 2; exe_wr_en = 1; exe_is_load = 1;
    #1; check("mul_c2_ignores", O_MUL);
    check_state("mul_state", 2'd1);
    next_cycle();
    clear_inputs(); exe_mul = 1;
    #1; check("mul_c3", O_MUL);
    next_cycle();
    #1; check("mul_done", O_DONE);
    next_cycle();
    exe_mul = 0;
    #1; check("mul_after", O_DEF);

    // HALT: detect, 2 drain cycles, then halted sticks
    next_cycle();
    exe_halt = 1;
    #1; check("halt_detect", O_DRAIN);
    next_cycle();
    exe_halt = 0;
    #1; check("drain_1", O_DRAIN);
    next_cycle();
    #1; check("drain_2", O_DRAIN);
    next_cycle();
    #1; check("halted", O_HALT);
    check_state("halt_state", 2'd3);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      exe_br_taken = k[0];
      exe_mul = ~k[0];
      #1; check("halt_sticky", O_HALT);
    end
    rst = 1;
    #1; check("halt_reset", O_ZERO);
    next_cycle();
    clear_inputs();
    rst = 0;
    #1; check("halt_exit_run", O_DEF);

    // Async reset mid-multiply, asserted between clock edges
    next_cycle();
    exe_mul = 1;
    #1; check("rmul_start", O_MUL);
    next_cycle();
    #1; check("rmul_c2", O_MUL);
    rst = 1;
    #1; check("rmul_rst_now", O_ZERO);
    check_state("rmul_rst_state", 2'd0);
    next_cycle();
    rst = 0;
    exe_mul = 0;
    #1; check("rmul_release", O_DEF);
    next_cycle();
    #1; check("rmul_no_done", O_DEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
